// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: machine word width and the buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    // One slot of the fetch buffer: where the word came from and the word itself.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer. Entries are allocated when a request is accepted,
// filled when its response returns, and popped by decode, all in order.
// Handshake: i_alloc, i_fill and i_pop are single-cycle strobes that the
// parent only raises when legal (space free, an unfilled entry exists,
// head entry filled respectively); i_flush wipes everything and wins.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_alloc,
    input  logic [XLEN-1:0]   i_alloc_pc,
    input  logic [XLEN-1:0]   i_alloc_pc4,
    input  logic              i_fill,
    input  logic [XLEN-1:0]   i_fill_instr,
    input  logic              i_pop,
    output fetch_entry_t      o_head,
    output logic              o_head_valid,
    output logic [CNT_W-1:0]  o_occ,
    output logic [CNT_W-1:0]  o_unfilled
);

    fetch_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0]  r_alloc_ptr;
    logic [PTR_W-1:0]  r_fill_ptr;
    logic [PTR_W-1:0]  r_head_ptr;
    logic [CNT_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_unfilled;

    // Allocate, fill and pop touch distinct slots, so all three may act in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_occ       <= '0;
            r_unfilled  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_occ       <= '0;
            r_unfilled  <= '0;
        end else begin
            if (i_alloc) begin
                r_mem[r_alloc_ptr] <= '{pc: i_alloc_pc, pc_plus_4: i_alloc_pc4,
                                        instr: '0, filled: 1'b0};
                r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
            end
            if (i_fill) begin
                r_mem[r_fill_ptr].instr  <= i_fill_instr;
                r_mem[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr <= r_fill_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_mem[r_head_ptr].filled <= 1'b0;
                r_head_ptr <= r_head_ptr + PTR_W'(1);
            end
            r_occ      <= r_occ + CNT_W'(i_alloc) - CNT_W'(i_pop);
            r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(i_fill);
        end
    end

    // Head slot is presented combinationally; it is only valid once filled.
    always_comb begin
        o_head       = r_mem[r_head_ptr];
        o_head_valid = r_mem[r_head_ptr].filled & (r_occ != '0);
        o_occ        = r_occ;
        o_unfilled   = r_unfilled;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Issues in-order fetches at pc, pairs each returned
// word with its pc in a small buffer and hands it to decode.
// Handshakes (valid/ready): a transfer happens in a cycle where both valid and
// ready are high; valid never depends on ready in the same direction, and
// imem responses carry no ready (the buffer always has room for them).
// pc_stall is low exactly in cycles where a fetch is accepted.
// A flush drops everything buffered and counts the wrong-path responses still
// in flight so they can be discarded as they return.
module fetch_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic            flush,
    output logic            pc_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_id_valid,
    input  logic            if_id_ready,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus_4
);

    import riscv_pkg::*;

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    // Wrong-path drops can stack across back-to-back flushes; leave headroom.
    localparam int DROP_W = CNT_W + 4;

    fetch_entry_t       w_head;
    logic               w_head_valid;
    logic [CNT_W-1:0]   w_occ;
    logic [CNT_W-1:0]   w_unfilled;
    logic               w_not_full;
    logic               w_accept;
    logic               w_drop_active;
    logic               w_rsp_owned;
    logic               w_fill;
    logic               w_pop;

    logic               r_run;
    logic [DROP_W-1:0]  r_drop_cnt;

    // Request, fill and pop qualification; flush suppresses all of them.
    always_comb begin
        w_not_full     = (w_occ != CNT_W'(DEPTH));
        imem_req_valid = r_run & ~flush & w_not_full;
        imem_req_addr  = pc;
        w_accept       = imem_req_valid & imem_req_ready;
        pc_stall       = ~w_accept;
        w_drop_active  = (r_drop_cnt != '0);
        // A response not being dropped belongs to the oldest unfilled entry.
        w_rsp_owned    = imem_rsp_valid & ~w_drop_active & (w_unfilled != '0);
        w_fill         = w_rsp_owned & ~flush;
        w_pop          = w_head_valid & if_id_ready & ~flush;
        if_id_valid     = w_head_valid;
        if_id_instr     = w_head.instr;
        if_id_pc        = w_head.pc;
        if_id_pc_plus_4 = w_head.pc_plus_4;
    end

    // Run flag: hold off fetching for the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // Drop counter: on flush, everything still in flight becomes wrong-path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_drop_cnt <= DROP_W'(w_unfilled) - DROP_W'(w_rsp_owned)
                        + (w_drop_active ? r_drop_cnt - DROP_W'(imem_rsp_valid) : '0);
        end else if (imem_rsp_valid && w_drop_active) begin
            r_drop_cnt <= r_drop_cnt - DROP_W'(1);
        end
    end

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk          (clk),
        .rst_n        (reset),
        .i_flush      (flush),
        .i_alloc      (w_accept),
        .i_alloc_pc   (pc),
        .i_alloc_pc4  (pc_plus_4),
        .i_fill       (w_fill),
        .i_fill_instr (imem_rsp_data),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_occ        (w_occ),
        .o_unfilled   (w_unfilled)
    );

    // A response with nothing outstanding is a memory protocol violation.
    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (w_drop_active || (w_unfilled != '0)));

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly downstream of program_counter; consumes pc/pc_plus_4 and issues in-order requests to instruction memory.
- Pairs each returned instruction word with its pc in a DEPTH-entry in-order buffer and presents it to decode over a valid/ready handshake.
- Drives pc_stall back to program_counter so the PC advances only when a fetch is accepted.
- Discards wrong-path fetches on a redirect (flush).

Parameters:
- XLEN, 32, width of pc and instruction word.
- DEPTH, 2, buffer entries and max outstanding requests; power of 2, >=2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  XLEN  current PC from program_counter.
- pc_plus_4  in  XLEN  pc+4 from program_counter.
- flush  in  1  redirect taken (pc_src from execute); pc holds target next cycle.
- pc_stall  out  1  1 = program_counter must hold pc this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  response word valid; responses return in request order, latency >=1 cycle.
- imem_rsp_data  in  XLEN  instruction word.
- if_id_valid  out  1  head entry holds a filled instruction.
- if_id_ready  in  1  decode accepts.
- if_id_instr  out  XLEN  instruction.
- if_id_pc  out  XLEN  its pc.
- if_id_pc_plus_4  out  XLEN  its pc+4.

Behaviour:
- Reset (reset=0, async): buffer empty, all entry filled flags 0, alloc/fill/head pointers 0, drop_cnt 0, run flag 0. Outputs: imem_req_valid=0, if_id_valid=0, pc_stall=1, if_id_* data 0.
- run flag sets on the first rising edge after reset deasserts; no request issues in that cycle.
- Buffer: DEPTH entries {pc, pc_plus_4, instr, filled}. Pointers: alloc (request), fill (response), head (decode). occupancy = allocated entries not yet popped, 0..DEPTH.
- Request: imem_req_valid = run & ~flush & (occupancy < DEPTH); imem_req_addr = pc. Combinational; no dependence on imem_req_ready.
- Accept (imem_req_valid & imem_req_ready): allocate entry at alloc ptr with pc, pc_plus_4, filled=0; alloc ptr++.
- pc_stall = ~(imem_req_valid & imem_req_ready). PC advances exactly once per accepted fetch.
- Response while drop_cnt>0: word discarded, drop_cnt--. Otherwise: write instr into entry at fill ptr, set filled, fill ptr++.
- A response with no outstanding request is a protocol error: ignore it. Simulation assertion only.
- Decode: if_id_valid = entry[head].filled & (occupancy>0). if_id_* come combinationally from the head entry. On if_id_valid & if_id_ready: pop, head ptr++.
- Best-case latency: request cycle N, response N+1, if_id_valid asserts N+2 (fill is registered).
- Simultaneous request, response and pop in one cycle: all three take effect; occupancy += accept - pop.
- Full (occupancy==DEPTH): no request, pc_stall=1, responses still fill, pops still allowed.
- Pointer wrap: modulo DEPTH; full and empty distinguished by an occupancy counter of width clog2(DEPTH)+1.
- Flush (priority over everything in that cycle):
  - No request issued; pop ignored; any response that cycle is discarded.
  - All entries cleared and pointers reset to equal values.
  - drop_cnt <= (allocated-but-unfilled count) - (imem_rsp_valid & drop_cnt==0 ? 1 : 0) + (drop_cnt>0 ? drop_cnt - imem_rsp_valid : 0).
  - Result: exactly the in-flight wrong-path responses are dropped.
- Requests resume the cycle after flush, using the target pc, even while drop_cnt>0. Those new entries fill only after the drops complete; in-order return guarantees correctness.
- Reset mid-operation: everything returns to the reset state immediately. The memory interface must also be reset by the same signal.

Decomposition:
- Shared package (riscv_pkg): XLEN constant; typedef fetch_entry_t {pc, pc_plus_4, instr, filled}.
- One natural sub-module: fetch_buffer (DEPTH-entry in-order alloc/fill/pop store with pointers and occupancy).
- Request logic and drop counter stay in fetch_stage.

Test Plan:
- Reset: hold reset=0 for 5 cycles, then release with pc=0 -> imem_req_valid=0, pc_stall=1, if_id_valid=0 throughout reset and the first cycle after release.
- Streaming: mem ready=1, 1-cycle latency, data=pc^32'hA5A5_0000, decode ready=1 -> if_id sequence pc=0,4,8,C, each instr matching, one per cycle after 2-cycle fill.
- Backpressure: if_id_ready=0 -> exactly DEPTH=2 requests (addr 0,4), then pc_stall=1 held. Raise ready -> delivers 0 then 4; fetch of 8 resumes.
- Flush: 2 outstanding (addr 8,C) with latency 3; flush with target 0x170 -> responses for 8,C dropped, first if_id_pc=0x170 with pc_plus_4=0x174, then 0x174.
- Simultaneous: occupancy 1, then request accept + response + pop in one cycle -> occupancy stays 1 and the order of if_id_pc is preserved.
- Reset mid-operation: reset asserted with 2 entries pending -> if_id_valid drops to 0 immediately. After release, first delivered pc=0.
